chime_alarm_ctrl: RTL and testbench

Parametrised successor to the interval chime/LED indicator in the clock datapath. Watches the BCD minutes/seconds of the timekeeping core and starts a chime on every minute boundary that is a multiple of a run-time interval. A chime beeps a configurable on/off pattern timed in seconds ticks and lights one of NUM_LEDS rotating indicator LEDs. Adds enable, acknowledge/silence, a disabled-interval encoding and a chime counter.

---
 rtl/chime_alarm_ctrl.sv | 142 ++++++++++++++
 tb/tb_chime_alarm_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/chime_alarm_ctrl.sv
// Interval chime controller: starts a beep pattern on minute boundaries that are
// multiples of a run-time interval and lights one of NUM_LEDS rotating LEDs.
module chime_alarm_ctrl #(
  parameter int NUM_LEDS          = 7,
  parameter int BEEP_PULSES       = 4,
  parameter int BEEP_ON_S         = 1,
  parameter int BEEP_OFF_S        = 1,
  parameter int BUZZER_ACTIVE_LOW = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic [7:0]                  minutes,
  input  logic [7:0]                  seconds,
  input  logic [5:0]                  interval,
  input  logic                        ack,
  output logic                        buzzer,
  output logic [NUM_LEDS-1:0]         leds,
  output logic [$clog2(NUM_LEDS)-1:0] led_index,
  output logic                        chime_active,
  output logic [7:0]                  chime_count
);

  localparam int IDX_W = $clog2(NUM_LEDS);
  localparam logic [3:0] ON_TICKS  = 4'(BEEP_ON_S);
  localparam logic [3:0] OFF_TICKS = 4'(BEEP_OFF_S);
  localparam logic [3:0] PULSES    = 4'(BEEP_PULSES);
  localparam logic BUZ_ON  = (BUZZER_ACTIVE_LOW != 0) ? 1'b0 : 1'b1;
  localparam logic BUZ_OFF = ~BUZ_ON;

  typedef enum logic [1:0] {IDLE, BEEP_ON, BEEP_OFF, HOLD} state_t;

  state_t           state, state_n;
  logic [3:0]       tick_cnt, tick_n;
  logic [3:0]       pulse_cnt, pulse_n;
  logic [IDX_W-1:0] idx_n;
  logic [7:0]       cnt_n;
  logic             primed;
  logic [7:0]       min_q, sec_q;
  logic             min_evt, sec_tick, match;
  logic [5:0]       min_bin;

  function automatic logic bcd_valid(input logic [7:0] d);
    return (d[7:4] <= 4'd9) && (d[3:0] <= 4'd9);
  endfunction

  function automatic logic [5:0] bcd_to_bin(input logic [7:0] d);
    return 6'(d[7:4]) * 6'd10 + 6'(d[3:0]);
  endfunction

  // Input sampling: data registers track every cycle and carry no reset
  always_ff @(posedge clk) begin
    min_q <= minutes;
    sec_q <= seconds;
  end

  assign min_evt  = primed && (minutes != min_q) && bcd_valid(minutes);
  assign sec_tick = primed && (seconds != sec_q) && bcd_valid(seconds);
  assign min_bin  = bcd_to_bin(minutes);
  // Above 59 no nonzero minute can be a multiple, so only 00 matches
  assign match    = (interval != 6'd0) &&
                    ((interval > 6'd59) ? (min_bin == 6'd0) : ((min_bin % interval) == 6'd0));

  always_comb begin
    state_n = state;
    tick_n  = tick_cnt;
    pulse_n = pulse_cnt;
    idx_n   = led_index;
    cnt_n   = chime_count;
    if (!en) begin
      state_n = IDLE;
    end else if (min_evt && (state != IDLE)) begin
      idx_n = (led_index == IDX_W'(NUM_LEDS - 1)) ? '0 : led_index + 1'b1;
      if (match) begin
        state_n = BEEP_ON;
        tick_n  = '0;
        pulse_n = '0;
        cnt_n   = chime_count + 8'd1;
      end else begin
        state_n = IDLE;
      end
    end else if (min_evt && match) begin
      state_n = BEEP_ON;
      tick_n  = '0;
      pulse_n = '0;
      cnt_n   = chime_count + 8'd1;
    end else begin
      case (state)
        BEEP_ON: begin
          if (ack) begin
            state_n = HOLD;
          end else if (sec_tick) begin
            if (tick_cnt + 4'd1 == ON_TICKS) begin
              tick_n  = '0;
              pulse_n = pulse_cnt + 4'd1;
              state_n = (pulse_cnt + 4'd1 == PULSES) ? HOLD : BEEP_OFF;
            end else begin
              tick_n = tick_cnt + 4'd1;
            end
          end
        end
        BEEP_OFF: begin
          if (ack) begin
            state_n = HOLD;
          end else if (sec_tick) begin
            if (tick_cnt + 4'd1 == OFF_TICKS) begin
              tick_n  = '0;
              state_n = BEEP_ON;
            end else begin
              tick_n = tick_cnt + 4'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Control state: FSM, counters and the post-reset priming flag
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      tick_cnt    <= '0;
      pulse_cnt   <= '0;
      led_index   <= '0;
      chime_count <= '0;
      primed      <= 1'b0;
    end else begin
      state       <= state_n;
      tick_cnt    <= tick_n;
      pulse_cnt   <= pulse_n;
      led_index   <= idx_n;
      chime_count <= cnt_n;
      primed      <= 1'b1;
    end
  end

  assign chime_active = (state != IDLE);
  assign buzzer       = (state == BEEP_ON) ? BUZ_ON : BUZ_OFF;
  assign leds         = chime_active ? (NUM_LEDS'(1) << led_index) : '0;

endmodule

// File: tb/tb_chime_alarm_ctrl.sv
// Scoreboard bench for chime_alarm_ctrl with default parameters (7 LEDs, 4 beeps,
// 1s on/off, active-low buzzer); expected output words are hand-derived per cycle.
module tb_chime_alarm_ctrl;

  logic       clk = 1'b0;
  logic       rst, en, ack;
  logic [7:0] minutes, seconds;
  logic [5:0] interval;
  logic       buzzer, chime_active;
  logic [6:0] leds;
  logic [2:0] led_index;
  logic [7:0] chime_count;

  typedef struct {
    logic [7:0]  mn;
    logic [7:0]  sc;
    logic [5:0]  iv;
    logic        en;
    logic        ack;
    logic        rs;
    logic [19:0] ex;
  } stim_t;

  stim_t       stim_q[$];
  logic [19:0] sb_q[$];
  int          vectors = 0;
  int          miscompares = 0;
  logic [5:0]  cur_iv = 6'd5;
  logic        cur_en = 1'b1;

  chime_alarm_ctrl dut (
    .clk(clk), .rst(rst), .en(en), .minutes(minutes), .seconds(seconds),
    .interval(interval), .ack(ack), .buzzer(buzzer), .leds(leds),
    .led_index(led_index), .chime_active(chime_active), .chime_count(chime_count)
  );

  always #5 clk = ~clk;

  // Packed expectation {buzzer, leds, led_index, chime_active, chime_count}
  function automatic logic [19:0] e(input bit on, input bit lit, input int idx, input int cnt);
    logic [6:0] l;
    l = lit ? 7'(1 << idx) : 7'd0;
    return {on ? 1'b0 : 1'b1, l, 3'(idx), lit, 8'(cnt)};
  endfunction

  function automatic logic [7:0] bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  task automatic add(input logic [7:0] mn, input logic [7:0] sc, input logic [19:0] ex,
                     input logic a = 1'b0, input logic r = 1'b0);
    stim_t s;
    s.mn = mn; s.sc = sc; s.iv = cur_iv; s.en = cur_en; s.ack = a; s.rs = r; s.ex = ex;
    stim_q.push_back(s);
  endtask

  task automatic apply(input stim_t s);
    minutes = s.mn; seconds = s.sc; interval = s.iv; en = s.en; ack = s.ack; rst = s.rs;
    sb_q.push_back(s.ex);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    stim_t s; logic [19:0] ex, got; int k = 0;
    cur_iv = 6'd5; cur_en = 1'b1;
    add(8'h00, 8'h00, e(0, 0, 0, 0), 0, 1);
    add(8'h00, 8'h00, e(0, 0, 0, 0), 0, 1);
    add(8'h04, 8'h58, e(0, 0, 0, 0));
    add(8'h04, 8'h58, e(0, 0, 0, 0));
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front(); apply(s);
      ex = sb_q.pop_front();
      got = {buzzer, leds, led_index, chime_active, chime_count};
      vectors++;
      if (got !== ex) begin
        miscompares++;
        $display("FAIL reset[%0d]: got %h required %h", k, got, ex);
      end
      k++;
    end
  endtask

  task automatic test_basic_chime();
    stim_t s; logic [19:0] ex, got; int k = 0;
    add(8'h05, 8'h00, e(1, 1, 0, 1));
    add(8'h05, 8'h00, e(1, 1, 0, 1));
    for (int t = 1; t <= 7; t++) begin
      add(8'h05, bcd(t), e((t % 2 == 0) && (t < 7), 1, 0, 1));
      add(8'h05, bcd(t), e((t % 2 == 0) && (t < 7), 1, 0, 1));
    end
    add(8'h06, 8'h07, e(0, 0, 1, 1));
    add(8'h10, 8'h07, e(1, 1, 1, 2));
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front(); apply(s);
      ex = sb_q.pop_front();
      got = {buzzer, leds, led_index, chime_active, chime_count};
      vectors++;
      if (got !== ex) begin
        miscompares++;
        $display("FAIL basic_chime[%0d]: got %h required %h", k, got, ex);
      end
      k++;
    end
  endtask

  task automatic test_interval1();
    stim_t s; logic [19:0] ex, got; int k = 0;
    cur_iv = 6'd1;
    for (int m = 0; m < 8; m++) add(bcd(11 + m), 8'h07, e(1, 1, (2 + m) % 7, 3 + m));
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front(); apply(s);
      ex = sb_q.pop_front();
      got = {buzzer, leds, led_index, chime_active, chime_count};
      vectors++;
      if (got !== ex) begin
        miscompares++;
        $display("FAIL interval1[%0d]: got %h required %h", k, got, ex);
      end
      k++;
    end
  endtask

  task automatic test_ack();
    stim_t s; logic [19:0] ex, got; int k = 0;
    cur_iv = 6'd5;
    add(8'h19, 8'h07, e(0, 0, 3, 10));
    add(8'h20, 8'h07, e(1, 1, 3, 11));
    add(8'h20, 8'h08, e(0, 1, 3, 11));
    add(8'h20, 8'h09, e(1, 1, 3, 11));
    add(8'h20, 8'h09, e(0, 1, 3, 11), 1);
    add(8'h20, 8'h10, e(0, 1, 3, 11));
    add(8'h20, 8'h11, e(0, 1, 3, 11), 1);
    add(8'h21, 8'h11, e(0, 0, 4, 11));
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front(); apply(s);
      ex = sb_q.pop_front();
      got = {buzzer, leds, led_index, chime_active, chime_count};
      vectors++;
      if (got !== ex) begin
        miscompares++;
        $display("FAIL ack[%0d]: got %h required %h", k, got, ex);
      end
      k++;
    end
  endtask

  task automatic test_disabled();
    stim_t s; logic [19:0] ex, got; int k = 0;
    cur_iv = 6'd0;
    add(8'h00, 8'h11, e(0, 0, 4, 11));
    add(8'h00, 8'h12, e(0, 0, 4, 11));
    cur_iv = 6'd5; cur_en = 1'b0;
    add(8'h05, 8'h12, e(0, 0, 4, 11));
    cur_en = 1'b1;
    add(8'h05, 8'h12, e(0, 0, 4, 11));
    add(8'h10, 8'h12, e(1, 1, 4, 12));
    cur_en = 1'b0;
    add(8'h10, 8'h12, e(0, 0, 4, 12));
    cur_en = 1'b1;
    add(8'h10, 8'h13, e(0, 0, 4, 12));
    add(8'h5A, 8'h13, e(0, 0, 4, 12));
    add(8'h15, 8'h13, e(1, 1, 4, 13));
    cur_iv = 6'd60;
    add(8'h00, 8'h13, e(1, 1, 5, 14));
    add(8'h30, 8'h13, e(0, 0, 6, 14));
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front(); apply(s);
      ex = sb_q.pop_front();
      got = {buzzer, leds, led_index, chime_active, chime_count};
      vectors++;
      if (got !== ex) begin
        miscompares++;
        $display("FAIL disabled[%0d]: got %h required %h", k, got, ex);
      end
      k++;
    end
  endtask

  task automatic test_rst_mid();
    stim_t s; logic [19:0] ex, got; int k = 0;
    cur_iv = 6'd5;
    add(8'h35, 8'h13, e(1, 1, 6, 15));
    add(8'h35, 8'h14, e(0, 1, 6, 15));
    add(8'h19, 8'h14, e(0, 0, 0, 0), 0, 1);
    add(8'h20, 8'h14, e(0, 0, 0, 0));
    add(8'h25, 8'h14, e(1, 1, 0, 1));
    add(8'h25, 8'h15, e(0, 1, 0, 1));
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front(); apply(s);
      ex = sb_q.pop_front();
      got = {buzzer, leds, led_index, chime_active, chime_count};
      vectors++;
      if (got !== ex) begin
        miscompares++;
        $display("FAIL rst_mid[%0d]: got %h required %h", k, got, ex);
      end
      k++;
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; ack = 1'b0;
    minutes = 8'h00; seconds = 8'h00; interval = 6'd5;
    test_reset();
    test_basic_chime();
    test_interval1();
    test_ack();
    test_disabled();
    test_rst_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
